// File: rtl/uart_loopback_top.sv
// UART 8N1 echo: receives bytes on iDATA, reports them on oDATA/oDONE and retransmits on oTXDATA.
// Optional macro STOP_CHECK_EN discards frames whose stop bit samples low.
module uart_loopback_top #(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk_s,
    input  logic       rstn_s,
    input  logic       iDATA,
    output logic [7:0] oDATA,
    output logic       oDONE,
    output logic       oTXDATA
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
`ifdef STOP_CHECK_EN
    localparam bit STOP_CHECK = 1'b1;
`else
    localparam bit STOP_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic              rx_meta_r, rx_sync_r;
    uart_state_e       rx_state_r, rx_state_s;
    logic [CW-1:0]     rx_cnt_r, rx_cnt_s;
    logic [2:0]        rx_idx_r, rx_idx_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic              rx_bad_r, rx_bad_s;
    logic [7:0]        data_r, data_s;
    logic              done_r, done_s;
    logic              stop_ok_s;

    logic [7:0]        pend_r, pend_s;
    logic              pend_full_r, pend_full_s;
    uart_state_e       tx_state_r, tx_state_s;
    logic [CW-1:0]     tx_cnt_r, tx_cnt_s;
    logic [2:0]        tx_idx_r, tx_idx_s;
    logic [7:0]        tx_shift_r, tx_shift_s;
    logic              tx_r, tx_s;
    logic              take_s;

    assign oDATA   = data_r;
    assign oDONE   = done_r;
    assign oTXDATA = tx_r;

    // Two-flop synchronizer for the asynchronous RX pin, preset to line idle.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= iDATA;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next-state: start validation at mid-bit, LSB-first data, stop sampling.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_idx_s   = rx_idx_r;
        rx_shift_s = rx_shift_r;
        rx_bad_s   = rx_bad_r;
        data_s     = data_r;
        done_s     = 1'b0;
        stop_ok_s  = rx_sync_r || !STOP_CHECK;
        case (rx_state_r)
            ST_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_s = ST_START;
                    rx_cnt_s   = '0;
                    rx_bad_s   = 1'b0;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == CNT_HALF_END) begin
                    rx_cnt_s = '0;
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_state_s = ST_DATA;
                        rx_idx_s   = 3'd0;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == CNT_BIT_END) begin
                    rx_cnt_s             = '0;
                    rx_shift_s[rx_idx_r] = rx_sync_r;
                    if (rx_idx_r == 3'd7) begin
                        rx_state_s = ST_STOP;
                    end else begin
                        rx_idx_s = rx_idx_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // A rejected stop bit parks here until the line returns high (break guard).
                if (rx_bad_r) begin
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                        rx_bad_s   = 1'b0;
                    end else begin
                        rx_state_s = ST_STOP;
                    end
                end else if (rx_cnt_r == CNT_BIT_END) begin
                    rx_cnt_s = '0;
                    if (stop_ok_s) begin
                        data_s     = rx_shift_r;
                        done_s     = 1'b1;
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_bad_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    // Pending byte (newest wins) and TX next-state.
    always_comb begin
        take_s      = (tx_state_r == ST_IDLE) && pend_full_r;
        pend_s      = pend_r;
        pend_full_s = pend_full_r;
        if (done_s) begin
            pend_s      = data_s;
            pend_full_s = 1'b1;
        end else if (take_s) begin
            pend_full_s = 1'b0;
        end else begin
            pend_full_s = pend_full_r;
        end

        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_idx_s   = tx_idx_r;
        tx_shift_s = tx_shift_r;
        tx_s       = tx_r;
        case (tx_state_r)
            ST_IDLE: begin
                if (pend_full_r) begin
                    tx_shift_s = pend_r;
                    tx_s       = 1'b0;
                    tx_cnt_s   = '0;
                    tx_state_s = ST_START;
                end else begin
                    tx_s = 1'b1;
                end
            end
            ST_START: begin
                if (tx_cnt_r == CNT_BIT_END) begin
                    tx_cnt_s   = '0;
                    tx_idx_s   = 3'd0;
                    tx_s       = tx_shift_r[0];
                    tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    tx_state_s = ST_DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == CNT_BIT_END) begin
                    tx_cnt_s = '0;
                    if (tx_idx_r == 3'd7) begin
                        tx_s       = 1'b1;
                        tx_state_s = ST_STOP;
                    end else begin
                        tx_idx_s   = tx_idx_r + 3'd1;
                        tx_s       = tx_shift_r[0];
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == CNT_BIT_END) begin
                    tx_cnt_s   = '0;
                    tx_state_s = ST_IDLE;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_s       = 1'b1;
                tx_cnt_s   = '0;
                tx_state_s = ST_IDLE;
            end
        endcase
    end

    // State registers for RX, pending byte and TX.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            rx_state_r  <= ST_IDLE;
            rx_cnt_r    <= '0;
            rx_idx_r    <= 3'd0;
            rx_shift_r  <= 8'h00;
            rx_bad_r    <= 1'b0;
            data_r      <= 8'h00;
            done_r      <= 1'b0;
            pend_r      <= 8'h00;
            pend_full_r <= 1'b0;
            tx_state_r  <= ST_IDLE;
            tx_cnt_r    <= '0;
            tx_idx_r    <= 3'd0;
            tx_shift_r  <= 8'h00;
            tx_r        <= 1'b1;
        end else begin
            rx_state_r  <= rx_state_s;
            rx_cnt_r    <= rx_cnt_s;
            rx_idx_r    <= rx_idx_s;
            rx_shift_r  <= rx_shift_s;
            rx_bad_r    <= rx_bad_s;
            data_r      <= data_s;
            done_r      <= done_s;
            pend_r      <= pend_s;
            pend_full_r <= pend_full_s;
            tx_state_r  <= tx_state_s;
            tx_cnt_r    <= tx_cnt_s;
            tx_idx_r    <= tx_idx_s;
            tx_shift_r  <= tx_shift_s;
            tx_r        <= tx_s;
        end
    end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Self-checking bench for uart_loopback_top: frame-level model of expected RX bytes and TX echoes.
module tb_uart_loopback_top;

    localparam int CPB = 12;
`ifdef STOP_CHECK_EN
    localparam bit STOP_CHK = 1'b1;
`else
    localparam bit STOP_CHK = 1'b0;
`endif

    logic       clk_s = 1'b0;
    logic       rstn_s;
    logic       iDATA;
    logic [7:0] oDATA;
    logic       oDONE;
    logic       oTXDATA;

    uart_loopback_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk_s  (clk_s),
        .rstn_s (rstn_s),
        .iDATA  (iDATA),
        .oDATA  (oDATA),
        .oDONE  (oDONE),
        .oTXDATA(oTXDATA)
    );

    always #10 clk_s = ~clk_s;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    int         tx_frames = 0;
    logic [7:0] last_data = 8'h00;
    logic [9:0] tx_last_frame = 10'h000;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    always @(posedge clk_s) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_s);
        #1;
    endtask

    // Drive one 8N1 frame; the model expects an echo only when the frame is accepted.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop || !STOP_CHK) begin
            exp_rx.push_back(b);
            exp_tx.push_back(b);
        end
        iDATA = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            iDATA = b[i];
            tick(CPB);
        end
        iDATA = stop;
        tick(CPB);
        iDATA = 1'b1;
    endtask

    task automatic do_reset();
        rstn_s = 1'b0;
        iDATA = 1'b1;
        exp_rx.delete();
        exp_tx.delete();
        last_data = 8'h00;
        #1;
        chk("rst_tx_immediate", oTXDATA, 1);
        chk("rst_done_immediate", oDONE, 0);
        tick(5);
        rstn_s = 1'b1;
        tick(20);
    endtask

    // RX compare: every cycle oDATA either holds or updates to the next expected byte.
    always @(negedge clk_s) begin
        if (rstn_s !== 1'b1) begin
            chk("rst_data", oDATA, 8'h00);
            chk("rst_done", oDONE, 0);
            chk("rst_tx", oTXDATA, 1);
        end else if (oDONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected_done oDATA=%0h expected no strobe (t=%0t)", oDATA, $time);
            end else begin
                last_data = exp_rx.pop_front();
                chk("rx_data", oDATA, last_data);
            end
        end else begin
            chk("rx_hold", oDATA, last_data);
        end
    end

    // TX decoder: checks each bit near both ends of its 12-cycle slot and the byte at mid-bit.
    task automatic tx_decode();
        logic [7:0] e;
        logic [9:0] fr;
        logic [9:0] obs;
        bit         abort;
        if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_start oTXDATA=0 expected idle 1 (t=%0t)", $time);
            repeat (10 * CPB - 1) @(negedge clk_s);
            return;
        end
        e = exp_tx.pop_front();
        fr = {1'b1, e, 1'b0};
        obs = 10'h000;
        abort = 1'b0;
        for (int o = 1; o < 10 * CPB && !abort; o++) begin
            @(negedge clk_s);
            if (rstn_s !== 1'b1) begin
                abort = 1'b1;
            end else begin
                if ((o % CPB) == 1 || (o % CPB) == CPB - 2) chk("tx_bit", oTXDATA, fr[o / CPB]);
                if ((o % CPB) == CPB / 2) obs[o / CPB] = oTXDATA;
            end
        end
        if (!abort) begin
            chk("tx_byte", obs[8:1], e);
            tx_last_frame = obs;
            tx_frames++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_s);
            if (rstn_s === 1'b1 && oTXDATA === 1'b0) tx_decode();
        end
    end

    int n_done;
    int n_tx;
    logic [7:0] seq [5] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'hC3};

    initial begin
        rstn_s = 1'b0;
        iDATA  = 1'b1;
        tick(5);
        chk("reset_odata", oDATA, 8'h00);
        chk("reset_odone", oDONE, 0);
        chk("reset_otx", oTXDATA, 1);
        rstn_s = 1'b1;
        tick(200);
        chk("idle_done_cnt", done_cnt, 0);
        chk("idle_otx", oTXDATA, 1);
        chk("idle_odata", oDATA, 8'h00);

        // Single 8'h55: latency window, literal data and literal TX frame.
        send_frame(8'h55, 1'b1);
        tick(200);
        checks++;
        if (done_cyc - start_cyc < 114 || done_cyc - start_cyc > 118) begin
            errors++;
            $display("FAIL done_latency actual=%0d expected 114..118", done_cyc - start_cyc);
        end
        chk("single_odata", oDATA, 8'h55);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_tx_frame", tx_last_frame, 10'b1010101010);
        chk("single_tx_frames", tx_frames, 1);

        // Five-byte sequence with 50-cycle idle gaps.
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b1);
            tick(50);
        end
        tick(250);
        chk("seq_done_cnt", done_cnt, 6);
        chk("seq_tx_frames", tx_frames, 6);
        chk("seq_last_odata", oDATA, 8'hC3);
        chk("seq_last_tx", tx_last_frame[8:1], 8'hC3);
        chk("seq_rx_drained", exp_rx.size(), 0);
        chk("seq_tx_drained", exp_tx.size(), 0);

        // 3-cycle glitch must be rejected.
        iDATA = 1'b0;
        tick(3);
        iDATA = 1'b1;
        tick(200);
        chk("glitch_done_cnt", done_cnt, 6);
        chk("glitch_tx_frames", tx_frames, 6);
        chk("glitch_otx", oTXDATA, 1);

`ifdef STOP_CHECK_EN
        send_frame(8'h81, 1'b0);
        tick(200);
        chk("badstop_done_cnt", done_cnt, 6);
        chk("badstop_odata", oDATA, 8'hC3);
        chk("badstop_tx_frames", tx_frames, 6);
        send_frame(8'h42, 1'b1);
        tick(250);
        chk("after_badstop_odata", oDATA, 8'h42);
        chk("after_badstop_tx", tx_last_frame[8:1], 8'h42);
        chk("after_badstop_done_cnt", done_cnt, 7);
`endif

        // Reset during RX data bit 4: frame aborted, no strobe.
        n_done = done_cnt;
        n_tx   = tx_frames;
        iDATA = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            iDATA = (8'h5A >> i) & 8'h01;
            tick(CPB);
        end
        iDATA = 1'b1;
        tick(CPB / 2);
        do_reset();
        tick(200);
        chk("rxabort_done_cnt", done_cnt, n_done);
        chk("rxabort_odata", oDATA, 8'h00);

        // Reset during TX data bit 3: echo aborted, line back high at once.
        send_frame(8'h96, 1'b1);
        tick(50);
        chk("txabort_in_bit3", oTXDATA, 0);
        do_reset();
        tick(200);
        chk("txabort_done_cnt", done_cnt, n_done + 1);
        chk("txabort_tx_frames", tx_frames, n_tx);
        chk("txabort_otx", oTXDATA, 1);

        send_frame(8'h7E, 1'b1);
        tick(250);
        chk("recover_odata", oDATA, 8'h7E);
        chk("recover_tx", tx_last_frame[8:1], 8'h7E);
        chk("recover_tx_frames", tx_frames, n_tx + 1);
        chk("recover_drained", exp_rx.size() + exp_tx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
